// File: rtl/grapheme_node_prot_pkg.sv
// Shared definitions for the grapheme fill node: frame limits, status bit map,
// rectangle command bundle and the fill FSM state type.
package grapheme_node_prot_pkg;

   localparam int unsigned RF_X_W      = 11;
   localparam int unsigned RF_Y_W      = 10;
   localparam int unsigned RF_COLOUR_W = 24;
   localparam int unsigned RF_STATUS_W = 32;

   localparam int unsigned MAX_X = 1280;
   localparam int unsigned MAX_Y = 720;

   localparam int unsigned RF_STS_BUSY     = 0;
   localparam int unsigned RF_STS_ERR_ZERO = 1;
   localparam int unsigned RF_STS_ERR_OOB  = 2;
   localparam int unsigned RF_STS_CNT_LSB  = 16;
   localparam int unsigned RF_CNT_W        = 16;

   typedef struct packed {
      logic [RF_X_W-1:0]      x;
      logic [RF_Y_W-1:0]      y;
      logic [RF_X_W-1:0]      w;
      logic [RF_Y_W-1:0]      h;
      logic [RF_COLOUR_W-1:0] colour;
   } rect_cmd_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } rf_state_t;

endpackage

// File: rtl/grapheme_raster_cntr.sv
// Raster-order x/y walker over a clipped rectangle; o_last is registered and
// flags the bottom-right pixel of the current rectangle.
module grapheme_raster_cntr
   import grapheme_node_prot_pkg::*;
#(
   parameter int unsigned X_W = 11,
   parameter int unsigned Y_W = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_load,
   input  logic           i_adv,
   input  logic [X_W-1:0] i_x0,
   input  logic [Y_W-1:0] i_y0,
   input  logic [X_W:0]   i_w,
   input  logic [Y_W:0]   i_h,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_last
);

   logic [X_W-1:0] r_x;
   logic [X_W-1:0] r_x0;
   logic [Y_W-1:0] r_y;
   logic [X_W:0]   r_xend;
   logic [Y_W:0]   r_yend;
   logic           r_last;

   logic           w_row_end;
   logic [X_W-1:0] w_nx;
   logic [Y_W-1:0] w_ny;

   assign w_row_end = ({1'b0, r_x} == r_xend);
   assign w_nx      = w_row_end ? r_x0 : r_x + X_W'(1);
   assign w_ny      = w_row_end ? r_y + Y_W'(1) : r_y;

   // End coordinates kept one bit wider so the compare never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_x0   <= '0;
         r_y    <= '0;
         r_xend <= '0;
         r_yend <= '0;
         r_last <= 1'b0;
      end else if (i_load) begin
         r_x    <= i_x0;
         r_x0   <= i_x0;
         r_y    <= i_y0;
         r_xend <= {1'b0, i_x0} + i_w - (X_W+1)'(1);
         r_yend <= {1'b0, i_y0} + i_h - (Y_W+1)'(1);
         r_last <= (i_w == (X_W+1)'(1)) && (i_h == (Y_W+1)'(1));
      end else if (i_adv) begin
         r_x    <= w_nx;
         r_y    <= w_ny;
         r_last <= ({1'b0, w_nx} == r_xend) && ({1'b0, w_ny} == r_yend);
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_last = r_last;

endmodule

// File: rtl/grapheme_rect_fill.sv
// Rectangle fill node: validates and clips one command, then streams its
// pixels in raster order with valid/ready, gated by node_en.
module grapheme_rect_fill
   import grapheme_node_prot_pkg::rect_cmd_t, grapheme_node_prot_pkg::rf_state_t,
          grapheme_node_prot_pkg::ST_IDLE, grapheme_node_prot_pkg::ST_FILL,
          grapheme_node_prot_pkg::RF_STS_BUSY, grapheme_node_prot_pkg::RF_STS_ERR_ZERO,
          grapheme_node_prot_pkg::RF_STS_ERR_OOB, grapheme_node_prot_pkg::RF_STS_CNT_LSB,
          grapheme_node_prot_pkg::RF_CNT_W;
#(
   parameter int unsigned X_W      = grapheme_node_prot_pkg::RF_X_W,
   parameter int unsigned Y_W      = grapheme_node_prot_pkg::RF_Y_W,
   parameter int unsigned COLOUR_W = grapheme_node_prot_pkg::RF_COLOUR_W,
   parameter int unsigned MAX_X    = grapheme_node_prot_pkg::MAX_X,
   parameter int unsigned MAX_Y    = grapheme_node_prot_pkg::MAX_Y,
   parameter int unsigned STATUS_W = grapheme_node_prot_pkg::RF_STATUS_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                node_en,
   input  logic                clear_flags,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [X_W-1:0]      cmd_x,
   input  logic [Y_W-1:0]      cmd_y,
   input  logic [X_W-1:0]      cmd_w,
   input  logic [Y_W-1:0]      cmd_h,
   input  logic [COLOUR_W-1:0] cmd_colour,
   output logic                pxl_valid,
   input  logic                pxl_ready,
   output logic [X_W-1:0]      pxl_x,
   output logic [Y_W-1:0]      pxl_y,
   output logic [COLOUR_W-1:0] pxl_colour,
   output logic                pxl_last,
   output logic [STATUS_W-1:0] status
);

   localparam logic [X_W:0] LP_MAX_X = (X_W+1)'(MAX_X);
   localparam logic [Y_W:0] LP_MAX_Y = (Y_W+1)'(MAX_Y);

   rf_state_t             r_state;
   logic                  r_rdy;
   logic                  r_pxl_valid;
   logic [COLOUR_W-1:0]   r_colour;
   logic                  r_err_zero;
   logic                  r_err_oob;
   logic [RF_CNT_W-1:0]   r_cnt;

   rect_cmd_t             w_cmd;
   logic                  w_cmd_hs;
   logic                  w_zero;
   logic                  w_oob;
   logic                  w_load;
   logic                  w_pxl_hs;
   logic                  w_done;
   logic                  w_cntr_last;
   logic [X_W:0]          w_room_x;
   logic [Y_W:0]          w_room_y;
   logic [X_W:0]          w_w_eff;
   logic [Y_W:0]          w_h_eff;
   logic [RF_CNT_W-1:0]   w_cnt_base;

   assign w_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};

   // r_rdy is only ever high in IDLE and is held low through reset.
   assign cmd_ready = r_rdy & node_en;
   assign w_cmd_hs  = cmd_valid & cmd_ready;

   assign w_zero   = (w_cmd.w == '0) || (w_cmd.h == '0);
   assign w_oob    = ({1'b0, w_cmd.x} >= LP_MAX_X) || ({1'b0, w_cmd.y} >= LP_MAX_Y);
   assign w_load   = w_cmd_hs & ~w_zero & ~w_oob;

   assign w_room_x = LP_MAX_X - {1'b0, w_cmd.x};
   assign w_room_y = LP_MAX_Y - {1'b0, w_cmd.y};
   assign w_w_eff  = ({1'b0, w_cmd.w} < w_room_x) ? {1'b0, w_cmd.w} : w_room_x;
   assign w_h_eff  = ({1'b0, w_cmd.h} < w_room_y) ? {1'b0, w_cmd.h} : w_room_y;

   assign w_pxl_hs = r_pxl_valid & pxl_ready;
   assign w_done   = w_pxl_hs & w_cntr_last;

   grapheme_raster_cntr #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_cntr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_adv  (w_pxl_hs),
      .i_x0   (w_cmd.x),
      .i_y0   (w_cmd.y),
      .i_w    (w_w_eff),
      .i_h    (w_h_eff),
      .o_x    (pxl_x),
      .o_y    (pxl_y),
      .o_last (w_cntr_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rdy       <= 1'b0;
         r_pxl_valid <= 1'b0;
         r_colour    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rdy <= 1'b1;
               if (w_load) begin
                  r_state     <= ST_FILL;
                  r_rdy       <= 1'b0;
                  r_pxl_valid <= 1'b1;
                  r_colour    <= w_cmd.colour;
               end
            end
            ST_FILL: begin
               if (w_done) begin
                  r_state     <= ST_IDLE;
                  r_rdy       <= 1'b1;
                  r_pxl_valid <= 1'b0;
               end else if (w_pxl_hs) begin
                  r_pxl_valid <= node_en;
               end else if (!r_pxl_valid && node_en) begin
                  r_pxl_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rdy       <= 1'b0;
               r_pxl_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pxl_valid  = r_pxl_valid;
   assign pxl_colour = r_colour;
   assign pxl_last   = w_cntr_last;

   // Clear applies first so a coinciding set or completion still lands.
   assign w_cnt_base = clear_flags ? '0 : r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_zero <= 1'b0;
         r_err_oob  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_err_zero <= (w_cmd_hs & w_zero) | (r_err_zero & ~clear_flags);
         r_err_oob  <= (w_cmd_hs & ~w_zero & w_oob) | (r_err_oob & ~clear_flags);
         r_cnt      <= (w_done && (w_cnt_base != '1)) ? w_cnt_base + RF_CNT_W'(1) : w_cnt_base;
      end
   end

   always_comb begin
      status                                = '0;
      status[RF_STS_BUSY]                   = (r_state == ST_FILL);
      status[RF_STS_ERR_ZERO]               = r_err_zero;
      status[RF_STS_ERR_OOB]                = r_err_oob;
      status[RF_STS_CNT_LSB +: RF_CNT_W]    = r_cnt;
   end

endmodule

// File: tb/tb_grapheme_rect_fill.sv
// Directed bench for grapheme_rect_fill: fills, stalls, clipping, errors,
// node_en gating and mid-fill reset.
module tb_grapheme_rect_fill;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        node_en;
   logic        clear_flags;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_x;
   logic [9:0]  cmd_y;
   logic [10:0] cmd_w;
   logic [9:0]  cmd_h;
   logic [23:0] cmd_colour;
   logic        pxl_valid;
   logic        pxl_ready;
   logic [10:0] pxl_x;
   logic [9:0]  pxl_y;
   logic [23:0] pxl_colour;
   logic        pxl_last;
   logic [31:0] status;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   grapheme_rect_fill #(
      .X_W      (11),
      .Y_W      (10),
      .COLOUR_W (24),
      .MAX_X    (1280),
      .MAX_Y    (720),
      .STATUS_W (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .node_en     (node_en),
      .clear_flags (clear_flags),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_w       (cmd_w),
      .cmd_h       (cmd_h),
      .cmd_colour  (cmd_colour),
      .pxl_valid   (pxl_valid),
      .pxl_ready   (pxl_ready),
      .pxl_x       (pxl_x),
      .pxl_y       (pxl_y),
      .pxl_colour  (pxl_colour),
      .pxl_last    (pxl_last),
      .status      (status)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input int x, input int y, input int w, input int h, input int col);
      chk("cmd_ready_before_send", cmd_ready, 1);
      cmd_x      = 11'(x);
      cmd_y      = 10'(y);
      cmd_w      = 11'(w);
      cmd_h      = 10'(h);
      cmd_colour = 24'(col);
      cmd_valid  = 1'b1;
      step();
      cmd_valid  = 1'b0;
   endtask

   task automatic chk_px(input string tag, input int x, input int y, input int last, input int col);
      chk({tag, "_valid"},  pxl_valid, 1);
      chk({tag, "_x"},      pxl_x, 64'(x));
      chk({tag, "_y"},      pxl_y, 64'(y));
      chk({tag, "_last"},   pxl_last, 64'(last));
      chk({tag, "_colour"}, pxl_colour, 64'(col));
   endtask

   initial begin
      int ex[4];
      int ey[4];
      int idx;

      rst_n       = 1'b0;
      node_en     = 1'b1;
      clear_flags = 1'b0;
      cmd_valid   = 1'b0;
      cmd_x       = '0;
      cmd_y       = '0;
      cmd_w       = '0;
      cmd_h       = '0;
      cmd_colour  = '0;
      pxl_ready   = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_pxl_valid", pxl_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_status", status, 0);
      chk("rst_pxl_x", pxl_x, 0);
      rst_n = 1'b1;
      step();
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_status", status, 0);

      // 2x2 at (10,20), ready high
      send_cmd(10, 20, 2, 2, 32'hFF0000);
      chk("t1_busy", status[0], 1);
      chk_px("t1_p0", 10, 20, 0, 32'hFF0000);
      chk("t1_cmd_ready_busy", cmd_ready, 0);
      step();
      chk_px("t1_p1", 11, 20, 0, 32'hFF0000);
      step();
      chk_px("t1_p2", 10, 21, 0, 32'hFF0000);
      step();
      chk_px("t1_p3", 11, 21, 1, 32'hFF0000);
      step();
      chk("t1_valid_after", pxl_valid, 0);
      chk("t1_busy_after", status[0], 0);
      chk("t1_count", status[31:16], 1);
      chk("t1_cmd_ready_after", cmd_ready, 1);

      // Same command with ready pattern 1,0,0,1 repeating
      ex = '{10, 11, 10, 11};
      ey = '{20, 20, 21, 21};
      pxl_ready = 1'b0;
      send_cmd(10, 20, 2, 2, 32'hFF0000);
      idx = 0;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         chk_px($sformatf("t2_c%0d", c), ex[idx], ey[idx], (idx == 3) ? 1 : 0, 32'hFF0000);
         pxl_ready = ((c % 4) == 0) || ((c % 4) == 3);
         step();
         if (pxl_ready) idx++;
      end
      chk("t2_pixels_accepted", idx, 4);
      chk("t2_valid_after", pxl_valid, 0);
      chk("t2_count", status[31:16], 2);
      pxl_ready = 1'b1;

      // Clip at the bottom-right corner
      send_cmd(1278, 719, 5, 3, 32'h00ABCD);
      chk_px("t3_p0", 1278, 719, 0, 32'h00ABCD);
      step();
      chk_px("t3_p1", 1279, 719, 1, 32'h00ABCD);
      step();
      chk("t3_valid_after", pxl_valid, 0);
      chk("t3_flags", status[2:1], 0);
      chk("t3_count", status[31:16], 3);

      // Error commands and flag clear
      send_cmd(5, 5, 0, 4, 32'h111111);
      chk("t4_zero_no_pixel", pxl_valid, 0);
      chk("t4_zero_flag", status[2:0], 3'b010);
      send_cmd(1280, 0, 1, 1, 32'h222222);
      chk("t4_oob_no_pixel", pxl_valid, 0);
      chk("t4_both_flags", status[2:0], 3'b110);
      step();
      chk("t4_still_no_pixel", pxl_valid, 0);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("t4_cleared_status", status, 0);

      // node_en dropped after the 2nd pixel of a 4x1 fill
      send_cmd(100, 50, 4, 1, 32'h00FF00);
      chk_px("t5_p0", 100, 50, 0, 32'h00FF00);
      step();
      chk_px("t5_p1", 101, 50, 0, 32'h00FF00);
      node_en = 1'b0;
      step();
      chk("t5_gated_valid0", pxl_valid, 0);
      chk("t5_gated_ready0", cmd_ready, 0);
      step();
      step();
      chk("t5_gated_valid1", pxl_valid, 0);
      chk("t5_gated_ready1", cmd_ready, 0);
      chk("t5_gated_busy", status[0], 1);
      node_en = 1'b1;
      step();
      chk_px("t5_p2", 102, 50, 0, 32'h00FF00);
      chk("t5_fill_ready", cmd_ready, 0);
      step();
      chk_px("t5_p3", 103, 50, 1, 32'h00FF00);
      step();
      chk("t5_valid_after", pxl_valid, 0);
      chk("t5_count", status[31:16], 1);
      chk("t5_cmd_ready_after", cmd_ready, 1);

      // Reset in the middle of a 10x10 fill
      send_cmd(0, 0, 10, 10, 32'h123456);
      for (int i = 0; i < 5; i++) step();
      chk("t6_mid_valid", pxl_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", pxl_valid, 0);
      chk("t6_rst_x", pxl_x, 0);
      chk("t6_rst_y", pxl_y, 0);
      chk("t6_rst_colour", pxl_colour, 0);
      chk("t6_rst_last", pxl_last, 0);
      chk("t6_rst_ready", cmd_ready, 0);
      chk("t6_rst_status", status, 0);
      step();
      rst_n = 1'b1;
      step();
      send_cmd(5, 6, 1, 1, 32'hABCDEF);
      chk_px("t6_single", 5, 6, 1, 32'hABCDEF);
      step();
      chk("t6_valid_after", pxl_valid, 0);
      chk("t6_count", status[31:16], 1);
      chk("t6_busy_after", status[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
